// File: rtl/mac_fp_pipe.sv
// Multi-lane floating-point multiply-accumulate pipeline: z = a*b + (c | accumulator).
// Finite operands only (subnormals flush to zero), round-to-nearest-even; beat_cnt enabled by MAC_FP_PIPE_BEAT_CNT_EN.
module mac_fp_pipe #(
  parameter int sig_width    = 23,
  parameter int exp_width    = 8,
  parameter int LANES        = 4,
  parameter int MULT_LATENCY = 1,
  parameter int ADD_LATENCY  = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic                                       acc_mode,
  input  logic                                       acc_clr,
  input  logic [LANES*(exp_width+sig_width+1)-1:0]   a,
  input  logic [LANES*(exp_width+sig_width+1)-1:0]   b,
  input  logic [LANES*(exp_width+sig_width+1)-1:0]   c,
  output logic                                       out_valid,
  output logic [LANES*(exp_width+sig_width+1)-1:0]   z,
  output logic [31:0]                                beat_cnt
);
  localparam int S    = sig_width;
  localparam int E    = exp_width;
  localparam int W    = E + S + 1;
  localparam int N    = S + 4;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int EMAX = (1 << E) - 1;
  localparam int ML   = MULT_LATENCY;
  localparam int AL   = ADD_LATENCY;
  localparam int CW   = (AL > 1) ? $clog2(AL) : 1;

  function automatic logic [W-1:0] fp_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic           sgn;
    int             e;
    logic [2*S+1:0] xm, ym, p;
    logic           up;
    logic [S:0]     mr;
    sgn = x[W-1] ^ y[W-1];
    if (x[W-2:S] == '0 || y[W-2:S] == '0) return {sgn, {(W-1){1'b0}}};
    xm = {{(S+1){1'b0}}, 1'b1, x[S-1:0]};
    ym = {{(S+1){1'b0}}, 1'b1, y[S-1:0]};
    p  = xm * ym;
    e  = int'(x[W-2:S]) + int'(y[W-2:S]) - BIAS;
    if (p[2*S+1]) e = e + 1;
    else          p = p << 1;
    up = p[S] & ((|p[S-1:0]) | p[S+1]);
    mr = {1'b0, p[2*S:S+1]} + {{S{1'b0}}, up};
    if (mr[S]) e = e + 1;
    if (e <= 0)    return {sgn, {(W-1){1'b0}}};
    if (e >= EMAX) return {sgn, {E{1'b1}}, {S{1'b0}}};
    return {sgn, e[E-1:0], mr[S-1:0]};
  endfunction

  function automatic logic [W-1:0] fp_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0]   hi, lo;
    logic [N-1:0]   mh, ml;
    logic [2*N-1:0] sh;
    logic [N:0]     s;
    logic [S:0]     mr;
    logic           up, found;
    int             e, d, lz;
    if (x[W-2:S] == '0 && y[W-2:S] == '0) return {x[W-1] & y[W-1], {(W-1){1'b0}}};
    if (x[W-2:S] == '0) return y;
    if (y[W-2:S] == '0) return x;
    if (x[W-2:0] >= y[W-2:0]) begin hi = x; lo = y; end
    else                      begin hi = y; lo = x; end
    e = int'(hi[W-2:S]);
    d = e - int'(lo[W-2:S]);
    if (d > N) d = N;
    // guard/round/sticky below the fraction; shifted-out bits collapse into sticky
    mh = {1'b1, hi[S-1:0], 3'b000};
    sh = {1'b1, lo[S-1:0], 3'b000, {N{1'b0}}} >> d;
    ml = sh[2*N-1:N];
    ml[0] = ml[0] | (|sh[N-1:0]);
    if (hi[W-1] == lo[W-1]) s = {1'b0, mh} + {1'b0, ml};
    else                    s = {1'b0, mh} - {1'b0, ml};
    if (s == '0) return '0;
    if (s[N]) begin
      s = {1'b0, s[N:2], s[1] | s[0]};
      e = e + 1;
    end else begin
      lz = 0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
        if (!found && s[i]) begin
          lz = N - 1 - i;
          found = 1'b1;
        end
      end
      s = s << lz;
      e = e - lz;
    end
    up = s[2] & (s[1] | s[0] | s[3]);
    mr = {1'b0, s[S+2:3]} + {{S{1'b0}}, up};
    if (mr[S]) e = e + 1;
    if (e <= 0)    return {hi[W-1], {(W-1){1'b0}}};
    if (e >= EMAX) return {hi[W-1], {E{1'b1}}, {S{1'b0}}};
    return {hi[W-1], e[E-1:0], mr[S-1:0]};
  endfunction

  typedef enum logic {READY, STALL} state_t;
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          accept;

  assign in_ready = !rst && (state_reg == READY);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= READY;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // an accepted accumulate beat blocks input until its sum can feed the next one
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      READY: if (accept && acc_mode) begin
        state_next = STALL;
        cnt_next   = CW'(AL - 1);
      end
      STALL: if (cnt_reg == '0) state_next = READY;
             else               cnt_next   = cnt_reg - CW'(1);
      default: state_next = READY;
    endcase
  end

  // multiplier stages plus the product register; c and flags ride alongside
  logic [LANES*W-1:0] mul_res;
  logic [LANES*W-1:0] mi_data [ML+1], mi_c [ML+1], m_data_reg [ML+1], m_c_reg [ML+1];
  logic               mi_v [ML+1], mi_mode [ML+1], mi_clr [ML+1];
  logic               m_v_reg [ML+1], m_mode_reg [ML+1], m_clr_reg [ML+1];

  always_comb begin
    mi_data[0] = mul_res;
    mi_c[0]    = c;
    mi_v[0]    = accept;
    mi_mode[0] = acc_mode;
    mi_clr[0]  = acc_clr;
    for (int k = 1; k <= ML; k++) begin
      mi_data[k] = m_data_reg[k-1];
      mi_c[k]    = m_c_reg[k-1];
      mi_v[k]    = m_v_reg[k-1];
      mi_mode[k] = m_mode_reg[k-1];
      mi_clr[k]  = m_clr_reg[k-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k <= ML; k++) begin
      if (rst) m_v_reg[k] <= 1'b0;
      else     m_v_reg[k] <= mi_v[k];
      if (mi_v[k]) begin
        m_data_reg[k] <= mi_data[k];
        m_c_reg[k]    <= mi_c[k];
        m_mode_reg[k] <= mi_mode[k];
        m_clr_reg[k]  <= mi_clr[k];
      end
    end
  end

  logic [LANES*W-1:0] addend, add_res, acc_reg;
  logic [LANES*W-1:0] ai_data [AL], ad_data_reg [AL];
  logic               ai_v [AL], ai_mode [AL], ad_v_reg [AL], ad_mode_reg [AL];
  logic               bypass;

  assign bypass = ad_v_reg[AL-1] && ad_mode_reg[AL-1];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign mul_res[gi*W +: W] = fp_mul(a[gi*W +: W], b[gi*W +: W]);
      assign addend[gi*W +: W]  = !m_mode_reg[ML] ? m_c_reg[ML][gi*W +: W] :
                                  m_clr_reg[ML]   ? '0 :
                                  bypass          ? ad_data_reg[AL-1][gi*W +: W] :
                                                    acc_reg[gi*W +: W];
      assign add_res[gi*W +: W] = fp_add(m_data_reg[ML][gi*W +: W], addend[gi*W +: W]);
    end
  endgenerate

  always_comb begin
    ai_data[0] = add_res;
    ai_v[0]    = m_v_reg[ML];
    ai_mode[0] = m_mode_reg[ML];
    for (int k = 1; k < AL; k++) begin
      ai_data[k] = ad_data_reg[k-1];
      ai_v[k]    = ad_v_reg[k-1];
      ai_mode[k] = ad_mode_reg[k-1];
    end
  end

  // stages load only on valid, so the last one (z) holds between results
  always_ff @(posedge clk) begin
    for (int k = 0; k < AL; k++) begin
      if (rst) begin
        ad_v_reg[k]    <= 1'b0;
        ad_mode_reg[k] <= 1'b0;
        ad_data_reg[k] <= '0;
      end else begin
        ad_v_reg[k] <= ai_v[k];
        if (ai_v[k]) begin
          ad_data_reg[k] <= ai_data[k];
          ad_mode_reg[k] <= ai_mode[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         acc_reg <= '0;
    else if (bypass) acc_reg <= ad_data_reg[AL-1];
  end

  assign z         = ad_data_reg[AL-1];
  assign out_valid = ad_v_reg[AL-1];

`ifdef MAC_FP_PIPE_BEAT_CNT_EN
  logic [31:0] beat_cnt_reg;
  always_ff @(posedge clk) begin
    if (rst)                                    beat_cnt_reg <= '0;
    else if (out_valid && beat_cnt_reg != '1)   beat_cnt_reg <= beat_cnt_reg + 32'd1;
  end
  assign beat_cnt = beat_cnt_reg;
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_fp_pipe.sv
// Directed bench for mac_fp_pipe: expected lane results are queued at drive time and
// checked, with their arrival cycle, whenever out_valid is seen.
module tb_mac_fp_pipe;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, acc_mode, acc_clr, out_valid;
  logic [127:0] a, b, c, z;
  logic [31:0]  beat_cnt;
  int           checks = 0, failures = 0, cyc = 0;

  typedef struct {
    logic [127:0] z;
    int           cyc;
  } exp_t;
  exp_t q[$];

  logic [31:0] fl [0:9] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

  mac_fp_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .acc_mode(acc_mode), .acc_clr(acc_clr), .a(a), .b(b), .c(c),
    .out_valid(out_valid), .z(z), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] all4(input logic [31:0] v);
    return {v, v, v, v};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] av, input logic [127:0] bv, input logic [127:0] cv,
                      input logic md, input logic clr, input logic push,
                      input logic [127:0] ez, output int stall);
    @(negedge clk);
    in_valid = 1'b1; a = av; b = bv; c = cv; acc_mode = md; acc_clr = clr;
    stall = 0;
    while (!in_ready && stall < 20) begin
      @(negedge clk);
      stall++;
    end
    check("in_ready_at_accept", 128'(in_ready), 128'(1));
    if (push) q.push_back('{ez, cyc + LAT});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      c = {$urandom, $urandom, $urandom, $urandom};
      acc_mode = 1'($urandom_range(0, 1));
      acc_clr  = 1'($urandom_range(0, 1));
    end
  endtask

  logic [127:0] prev_z;
  logic         prev_rst = 1'b1;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid) begin
      if (q.size() == 0) check("unexpected_out_valid", 128'(out_valid), 128'(0));
      else begin
        e = q.pop_front();
        check("z", z, e.z);
        check("out_cycle", 128'(cyc), 128'(e.cyc));
      end
    end else if (!rst && !prev_rst) begin
      check("z_hold", z, prev_z);
    end
    prev_z   = z;
    prev_rst = rst;
  end

  initial begin : stim
    int st, t;
    rst = 1'b1; in_valid = 1'b0; acc_mode = 1'b0; acc_clr = 1'b0; a = '0; b = '0; c = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_z", z, 128'(0));
    check("rst_beat_cnt", 128'(beat_cnt), 128'(0));
    rst = 1'b0;
    #1 check("in_ready_after_rst", 128'(in_ready), 128'(1));

    // 1*2+3 on every lane
    send(all4(fl[1]), all4(fl[2]), all4(fl[3]), 1'b0, 1'b0, 1'b1, all4(fl[5]), st);
    idle(6);
    // mixed signs, exact cancellation, small product
    send({32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40400000},
         {32'h3F000000, 32'h40000000, 32'h3FC00000, 32'hBF800000},
         {32'h00000000, 32'h40400000, 32'hC0100000, 32'h3F000000}, 1'b0, 1'b0, 1'b1,
         {32'h3E800000, 32'h40A00000, 32'h00000000, 32'hC0200000}, st);
    // round-to-nearest-even tie and round-up, 3*3, 1 + -1
    send({32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3F800000},
         {32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3F800000},
         {32'hBF800000, 32'h00000000, 32'h33800001, 32'h33800000}, 1'b0, 1'b0, 1'b1,
         {32'h00000000, 32'h41100000, 32'h3F800001, 32'h3F800000}, st);
    idle(6);

    // accumulate 1.0 four times, clearing on the first
    for (int k = 0; k < 4; k++) begin
      send(all4(fl[1]), all4(fl[1]), all4(fl[9]), 1'b1, (k == 0), 1'b1, all4(fl[k+1]), st);
      check("acc_stall", 128'(st), (k == 0) ? 128'(0) : 128'(2));
    end
    // 0*0 + accumulator reads the accumulator back
    send('0, '0, all4(fl[7]), 1'b1, 1'b0, 1'b1, all4(fl[4]), st);
    check("acc_stall_readback", 128'(st), 128'(2));
    idle(6);

    // eight back-to-back non-accumulate beats, acc_clr don't-care
    for (int j = 0; j < 8; j++) begin
      send(all4(fl[1]), all4(fl[1]), all4(fl[j]), 1'b0, 1'b1, 1'b1, all4(fl[j+1]), st);
      check("no_stall", 128'(st), 128'(0));
    end
    idle(6);

    // per-lane independence
    send({fl[4], fl[3], fl[2], fl[1]}, all4(fl[2]), '0, 1'b0, 1'b0, 1'b1,
         {fl[8], fl[6], fl[4], fl[2]}, st);
    idle(6);
    // non-accumulate beats left the accumulator at 4.0
    send('0, '0, '0, 1'b1, 1'b0, 1'b1, all4(fl[4]), st);
    idle(6);

    // reset with three beats in flight
    for (int j = 0; j < 3; j++) send(all4(fl[1]), all4(fl[1]), all4(fl[1]), 1'b0, 1'b0, 1'b0, '0, st);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_z", z, 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 check("in_ready_after_midrst", 128'(in_ready), 128'(1));
    idle(10);
    // accumulator cleared: 1*1 + 0
    send(all4(fl[1]), all4(fl[1]), all4(fl[5]), 1'b1, 1'b0, 1'b1, all4(fl[1]), st);
    idle(6);

    // beat counter over five results
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("beat_cnt_rst", 128'(beat_cnt), 128'(0));
    rst = 1'b0;
    for (int j = 0; j < 5; j++) send(all4(fl[1]), all4(fl[2]), all4(fl[3]), 1'b0, 1'b0, 1'b1, all4(fl[5]), st);
    idle(8);
`ifdef MAC_FP_PIPE_BEAT_CNT_EN
    check("beat_cnt", 128'(beat_cnt), 128'(5));
`else
    check("beat_cnt", 128'(beat_cnt), 128'(0));
`endif

    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", 128'(q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_fp_pipe.md
MAC_FP_PIPE -- requirements
Module: mac_fp_pipe

Interface
REQ-001 SHALL have parameter sig_width, default 23, mantissa bits per element.
REQ-002 SHALL have parameter exp_width, default 8, exponent bits per element; element width W = exp_width+sig_width+1.
REQ-003 SHALL have parameter LANES, default 4, number of independent MAC lanes.
REQ-004 SHALL have parameter MULT_LATENCY, default 1, latency of each lane's FP multiplier core.
REQ-005 SHALL have parameter ADD_LATENCY, default 2, latency of each lane's FP adder core.
REQ-006 SHALL have ports, one per line:
 clk  in  1  sole clock, rising edge.
 rst  in  1  reset, synchronous and active-high.
 in_valid  in  1  input beat present.
 in_ready  out  1  beat accepted when in_valid & in_ready.
 acc_mode  in  1  1: addend is lane accumulator; 0: addend is c.
 acc_clr  in  1  with acc_mode=1, addend is +0.0 for this beat.
 a  in  LANES*W  multiplicands, lane i at [i*W +: W].
 b  in  LANES*W  multipliers.
 c  in  LANES*W  external addends.
 out_valid  out  1  z holds a result.
 z  out  LANES*W  per-lane a*b+addend.
 beat_cnt  out  32  count of out_valid beats.

Function
REQ-007 SHALL compute, per lane, z = a*b + addend, with the product registered once between multiplier and adder.
REQ-008 SHALL assert out_valid exactly L = MULT_LATENCY+1+ADD_LATENCY cycles after the accepting cycle, one cycle per accepted beat, in order.
REQ-009 SHALL delay c and the acc_mode/acc_clr flags by MULT_LATENCY+1 cycles to align with the registered product.
REQ-010 SHALL hold z unchanged while out_valid is low.
REQ-011 SHALL keep a W-bit accumulator per lane, updated with that lane's z only on out_valid cycles of acc_mode beats; non-acc beats never modify it.
REQ-012 SHALL take the acc_mode addend from z when an acc_mode result is on z in the adder-input cycle (bypass), else from the accumulator register.
REQ-013 SHALL drive in_ready low for exactly ADD_LATENCY cycles following each accepted acc_mode beat (stall counter, states READY/STALL); it SHALL be high at all other times outside reset.
REQ-014 SHALL accept non-acc beats back-to-back every cycle with no stall.
REQ-015 SHALL ignore a, b, c, acc_mode, acc_clr whenever the beat is not accepted.
REQ-016 SHALL treat acc_clr as don't-care when acc_mode=0.
REQ-017 SHALL operate all lanes in lockstep under one in_valid/in_ready/out_valid.

Reset
REQ-018 SHALL, on rst high at a clock edge, clear all in-flight valid bits, the stall counter (READY), every accumulator (+0.0), z (0), out_valid (0) and beat_cnt (0).
REQ-019 SHALL drive in_ready low while rst is high and high in the first cycle after rst falls.
REQ-020 SHALL discard beats in flight when rst asserts mid-operation; no out_valid for them afterwards.

Configuration
REQ-021 SHALL, with macro MAC_FP_PIPE_BEAT_CNT_EN defined, increment beat_cnt by one on each out_valid cycle, saturating at 0xFFFFFFFF.
REQ-022 SHALL, without MAC_FP_PIPE_BEAT_CNT_EN, tie beat_cnt to 0 and instantiate no counter logic.

Verification
REQ-023 Single beat, defaults, acc_mode=0, all lanes a=0x3F800000, b=0x40000000, c=0x40400000 -> out_valid at cycle 4, z lanes=0x40A00000.
REQ-024 Four acc_mode beats, a=b=0x3F800000, first with acc_clr=1 -> in_ready low 2 cycles after each, final z=0x40800000, accumulator=0x40800000.
REQ-025 Eight consecutive acc_mode=0 beats, in_valid held high -> in_ready never low, out_valid high 8 consecutive cycles, order preserved.
REQ-026 Distinct per-lane values (lane i: a=i+1.0, b=2.0, c=0) -> lane i z = 2*(i+1).0, no cross-lane mixing.
REQ-027 rst pulsed 2 cycles after accepting 3 beats -> no out_valid afterwards, z=0, accumulators 0, in_ready high the cycle after rst.
REQ-028 With MAC_FP_PIPE_BEAT_CNT_EN, 5 accepted beats -> beat_cnt=5; without it -> beat_cnt=0.
